memory_arbiter: RTL and testbench

//  Shares one 4x8 memory_system between two requesters (0: switch panel, 1: auto-fill unit).

---
 rtl/memory_arbiter_pkg.sv | 16 +
 rtl/rr_arbiter2.sv | 24 ++
 rtl/memory_arbiter.sv | 97 +++++++++
 tb/tb_memory_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/memory_arbiter_pkg.sv
// Shared types for the two-requester memory arbiter.
// State encoding and default bus widths.
package memory_arbiter_pkg;

  localparam int DATA_W_D = 8;
  localparam int ADDR_W_D = 2;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    RDONE
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter.
// Pointer names the favoured requester on a tie.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr;

  always_comb begin
    grant = req;
    if (&req) grant = ptr ? 2'b10 : 2'b01;
  end

  // After a grant the other requester becomes favoured
  always_ff @(posedge clk) begin
    if (reset) ptr <= 1'b0;
    else if (advance && |grant) ptr <= grant[0];
  end

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates two requesters onto one small byte memory.
// Writes run setup -> store strobe -> hold.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int DATA_W        = DATA_W_D,
  parameter int ADDR_W        = ADDR_W_D,
  parameter int STROBE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_store,
  input  logic [DATA_W-1:0] mem_memory
);

  localparam int CW = $clog2(STROBE_CYCLES + 1);
  localparam logic [CW-1:0] SC = CW'(STROBE_CYCLES);

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [1:0]    grant;
  logic          g_sel;
  logic          g_we;
  logic          start;

  assign start = (state == IDLE) && (req0 || req1);

  rr_arbiter2 u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     ({req1, req0}),
    .advance (state == IDLE),
    .grant   (grant)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = SETUP;
      SETUP:   state_n = g_we ? STROBE : RDONE;
      STROBE:  if (cnt == CW'(1)) state_n = HOLD;
      HOLD:    state_n = IDLE;
      RDONE:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      g_sel     <= 1'b0;
      g_we      <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      mem_store <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      state     <= state_n;
      mem_store <= (state_n == STROBE);
      if (start) begin
        g_sel    <= grant[1];
        g_we     <= grant[1] ? we1 : we0;
        mem_addr <= grant[1] ? addr1 : addr0;
        mem_data <= grant[1] ? wdata1 : wdata0;
      end
      if (state == SETUP) begin
        cnt <= SC;
        // Address is already stable, so read data is ready for the ack cycle
        if (!g_we && g_sel) rdata1 <= mem_memory;
        if (!g_we && !g_sel) rdata0 <= mem_memory;
      end
      if (state == STROBE) cnt <= cnt - CW'(1);
    end
  end

  assign busy = (state != IDLE);
  assign ack0 = (state == HOLD || state == RDONE) && !g_sel;
  assign ack1 = (state == HOLD || state == RDONE) && g_sel;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a behavioural 4x8 memory.
// Runs a 1-cycle and a 3-cycle strobe instance from shared stimulus.
module tb_memory_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [1:0] addr0 = '0, addr1 = '0;
  logic [7:0] wdata0 = '0, wdata1 = '0;

  logic       a_ack0, a_ack1, a_busy, a_store;
  logic [7:0] a_rd0, a_rd1, a_mdata, a_mem;
  logic [1:0] a_maddr;
  logic       b_ack0, b_ack1, b_busy, b_store;
  logic [7:0] b_rd0, b_rd1, b_mdata, b_mem;
  logic [1:0] b_maddr;

  logic [7:0] mema [4];
  logic [7:0] memb [4];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  memory_arbiter #(.STROBE_CYCLES(1)) u_a (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .ack0(a_ack0), .rdata0(a_rd0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack1(a_ack1), .rdata1(a_rd1),
    .busy(a_busy), .mem_addr(a_maddr), .mem_data(a_mdata),
    .mem_store(a_store), .mem_memory(a_mem)
  );

  memory_arbiter #(.STROBE_CYCLES(3)) u_b (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .ack0(b_ack0), .rdata0(b_rd0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .ack1(b_ack1), .rdata1(b_rd1),
    .busy(b_busy), .mem_addr(b_maddr), .mem_data(b_mdata),
    .mem_store(b_store), .mem_memory(b_mem)
  );

  initial begin
    for (int i = 0; i < 4; i++) begin
      mema[i] = '0;
      memb[i] = '0;
    end
  end

  always @(posedge clk) begin
    if (a_store) mema[a_maddr] <= a_mdata;
    if (b_store) memb[b_maddr] <= b_mdata;
  end

  assign a_mem = mema[a_maddr];
  assign b_mem = memb[b_maddr];

  typedef struct {
    logic       rst, r0, w0;
    logic [1:0] a0;
    logic [7:0] d0;
    logic       r1, w1;
    logic [1:0] a1;
    logic [7:0] d1;
    logic       st, k0, k1, bz;
    logic [7:0] q0, q1;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(
    int rst, int r0, int w0, int a0, int d0,
    int r1, int w1, int a1, int d1,
    int st, int k0, int k1, int bz, int q0, int q1);
    vec_t x;
    x.rst = rst[0]; x.r0 = r0[0]; x.w0 = w0[0];
    x.a0 = a0[1:0]; x.d0 = d0[7:0];
    x.r1 = r1[0]; x.w1 = w1[0];
    x.a1 = a1[1:0]; x.d1 = d1[7:0];
    x.st = st[0]; x.k0 = k0[0]; x.k1 = k1[0]; x.bz = bz[0];
    x.q0 = q0[7:0]; x.q1 = q1[7:0];
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int which, output int cyc);
    cyc = 0;
    while (cyc < 12) begin
      step();
      cyc++;
      if ((which == 0) ? a_ack0 : a_ack1) break;
    end
  endtask

  initial begin
    int   c;
    logic [7:0] sm, am;

    // rst r0 w0 a0 d0 | r1 w1 a1 d1 | st k0 k1 bz q0 q1
    tbl.push_back(v(1,0,0,0,0,    0,0,0,0,    0,0,0,0,0,0));
    tbl.push_back(v(1,0,0,0,0,    0,0,0,0,    0,0,0,0,0,0));
    // write A5 to addr 2 from requester 0
    tbl.push_back(v(0,1,1,2,'hA5, 0,0,0,0,    0,0,0,0,0,0));
    tbl.push_back(v(0,1,1,2,'hA5, 0,0,0,0,    0,0,0,1,0,0));
    tbl.push_back(v(0,1,1,2,'hA5, 0,0,0,0,    1,0,0,1,0,0));
    tbl.push_back(v(0,0,1,2,'hA5, 0,0,0,0,    0,1,0,1,0,0));
    tbl.push_back(v(0,0,0,0,0,    0,0,0,0,    0,0,0,0,0,0));
    // read addr 2 from requester 1
    tbl.push_back(v(0,0,0,0,0,    1,0,2,0,    0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,    1,0,2,0,    0,0,0,1,0,0));
    tbl.push_back(v(0,0,0,0,0,    0,0,2,0,    0,0,1,1,0,'hA5));
    tbl.push_back(v(0,0,0,0,0,    0,0,0,0,    0,0,0,0,0,'hA5));
    // write aborted by reset during the strobe
    tbl.push_back(v(0,0,0,0,0,    1,1,1,'h3C, 0,0,0,0,0,'hA5));
    tbl.push_back(v(0,0,0,0,0,    1,1,1,'h3C, 0,0,0,1,0,'hA5));
    tbl.push_back(v(1,0,0,0,0,    1,1,1,'h3C, 1,0,0,1,0,'hA5));
    tbl.push_back(v(1,0,0,0,0,    0,0,0,0,    0,0,0,0,0,0));
    tbl.push_back(v(1,0,0,0,0,    0,0,0,0,    0,0,0,0,0,0));
    // contention: both read addr 2, alternate 0,1,0,1
    tbl.push_back(v(0,1,0,2,0,    1,0,2,0,    0,0,0,0,0,0));
    tbl.push_back(v(0,1,0,2,0,    1,0,2,0,    0,0,0,1,0,0));
    tbl.push_back(v(0,1,0,2,0,    1,0,2,0,    0,1,0,1,'hA5,0));
    tbl.push_back(v(0,1,0,2,0,    1,0,2,0,    0,0,0,0,'hA5,0));
    tbl.push_back(v(0,1,0,2,0,    1,0,2,0,    0,0,0,1,'hA5,0));
    tbl.push_back(v(0,1,0,2,0,    1,0,2,0,    0,0,1,1,'hA5,'hA5));
    tbl.push_back(v(0,1,0,2,0,    1,0,2,0,    0,0,0,0,'hA5,'hA5));
    tbl.push_back(v(0,1,0,2,0,    1,0,2,0,    0,0,0,1,'hA5,'hA5));
    tbl.push_back(v(0,1,0,2,0,    1,0,2,0,    0,1,0,1,'hA5,'hA5));
    tbl.push_back(v(0,1,0,2,0,    1,0,2,0,    0,0,0,0,'hA5,'hA5));
    tbl.push_back(v(0,1,0,2,0,    1,0,2,0,    0,0,0,1,'hA5,'hA5));
    tbl.push_back(v(0,0,0,2,0,    0,0,2,0,    0,0,1,1,'hA5,'hA5));
    tbl.push_back(v(0,0,0,0,0,    0,0,0,0,    0,0,0,0,'hA5,'hA5));

    foreach (tbl[i]) begin
      step();
      reset = tbl[i].rst;
      req0 = tbl[i].r0; we0 = tbl[i].w0;
      addr0 = tbl[i].a0; wdata0 = tbl[i].d0;
      req1 = tbl[i].r1; we1 = tbl[i].w1;
      addr1 = tbl[i].a1; wdata1 = tbl[i].d1;
      #1;
      chk($sformatf("v%0d store", i), 32'(a_store), 32'(tbl[i].st));
      chk($sformatf("v%0d ack0", i), 32'(a_ack0), 32'(tbl[i].k0));
      chk($sformatf("v%0d ack1", i), 32'(a_ack1), 32'(tbl[i].k1));
      chk($sformatf("v%0d busy", i), 32'(a_busy), 32'(tbl[i].bz));
      chk($sformatf("v%0d rdata0", i), 32'(a_rd0), 32'(tbl[i].q0));
      chk($sformatf("v%0d rdata1", i), 32'(a_rd1), 32'(tbl[i].q1));
    end

    // inputs change and req drops after grant; original write completes
    step();
    req0 = 1'b1; we0 = 1'b1; addr0 = 2'd3; wdata0 = 8'h5A;
    #1;
    chk("stab idle busy", 32'(a_busy), 32'd0);
    step();
    req0 = 1'b0; addr0 = 2'd0; wdata0 = 8'hFF;
    #1;
    chk("stab setup addr", 32'(a_maddr), 32'd3);
    chk("stab setup data", 32'(a_mdata), 32'h5A);
    chk("stab setup store", 32'(a_store), 32'd0);
    step();
    chk("stab strobe addr", 32'(a_maddr), 32'd3);
    chk("stab strobe data", 32'(a_mdata), 32'h5A);
    chk("stab strobe store", 32'(a_store), 32'd1);
    step();
    chk("stab hold ack0", 32'(a_ack0), 32'd1);
    chk("stab hold addr", 32'(a_maddr), 32'd3);
    chk("stab hold store", 32'(a_store), 32'd0);
    step();
    chk("stab idle addr", 32'(a_maddr), 32'd3);
    chk("stab idle data", 32'(a_mdata), 32'h5A);

    req1 = 1'b1; we1 = 1'b0; addr1 = 2'd3;
    wait_ack(1, c);
    req1 = 1'b0;
    chk("rd3 latency", 32'(c), 32'd2);
    chk("rd3 rdata1", 32'(a_rd1), 32'h5A);
    step();
    req0 = 1'b1; we0 = 1'b0; addr0 = 2'd0;
    wait_ack(0, c);
    req0 = 1'b0;
    chk("rd0 latency", 32'(c), 32'd2);
    chk("rd0 rdata0", 32'(a_rd0), 32'h00);

    // three-cycle strobe instance
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    req0 = 1'b1; we0 = 1'b1; addr0 = 2'd1; wdata0 = 8'hC3;
    sm = '0;
    am = '0;
    for (int i = 1; i < 8; i++) begin
      step();
      sm[i] = b_store;
      am[i] = b_ack0;
      if (b_ack0) req0 = 1'b0;
    end
    req0 = 1'b0;
    chk("s3 store cycles", 32'(sm), 32'h1C);
    chk("s3 ack cycle", 32'(am), 32'h20);
    chk("s3 written", 32'(memb[1]), 32'hC3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
